batch_norm_pipe: RTL and testbench

BATCH_NORM_PIPE -- requirements
Module: batch_norm_pipe

---
 rtl/batch_norm_pipe.sv | 143 ++++++++++++++
 tb/tb_batch_norm_pipe.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/batch_norm_pipe.sv
// rtl/batch_norm_pipe.sv - two-stage per-channel batch-norm affine update with saturation
// Per-channel factor/addend table feeds an S1 term register and an S2 saturating sum register.
module batch_norm_pipe #(
    parameter int WIDTH        = 6,
    parameter int ADDEND_WIDTH = WIDTH - 2,
    parameter int CHANNELS     = 4,
    parameter int CH_W         = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           cfg_we,
    input  logic [CH_W-1:0]                cfg_ch,
    input  logic [3:0]                     cfg_factor,
    input  logic signed [ADDEND_WIDTH-1:0] cfg_addend,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [CH_W-1:0]                in_ch,
    input  logic signed [WIDTH-1:0]        u,
    input  logic signed [WIDTH-1:0]        z,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [CH_W-1:0]                out_ch,
    output logic signed [WIDTH-1:0]        u_out,
    output logic                           out_sat
);
    localparam int IW = WIDTH + 4;
    localparam logic signed [IW-1:0] SAT_MAX = IW'((1 << (WIDTH - 1)) - 1);
    localparam logic signed [IW-1:0] SAT_MIN = ~SAT_MAX;

    logic [3:0]                     r_factor [CHANNELS];
    logic signed [ADDEND_WIDTH-1:0] r_addend [CHANNELS];

    logic                    r_v1;
    logic [CH_W-1:0]         r_ch1;
    logic signed [IW-1:0]    r_base;
    logic signed [IW-1:0]    r_t0;
    logic signed [IW-1:0]    r_t1;
    logic                    r_out_valid;
    logic [CH_W-1:0]         r_out_ch;
    logic signed [WIDTH-1:0] r_u_out;
    logic                    r_out_sat;

    logic                           w_adv;
    logic [3:0]                     w_factor_raw;
    logic [3:0]                     w_code;
    logic signed [ADDEND_WIDTH-1:0] w_addend;
    logic signed [IW-1:0]           w_zx;
    logic signed [IW-1:0]           w_base;
    logic signed [IW-1:0]           w_t0;
    logic signed [IW-1:0]           w_t1;
    logic signed [IW-1:0]           w_sum;
    logic signed [WIDTH-1:0]        w_sat_val;
    logic                           w_clamp;

    assign w_adv     = !r_out_valid || out_ready;
    assign in_ready  = w_adv;
    assign out_valid = r_out_valid;
    assign out_ch    = r_out_ch;
    assign u_out     = r_u_out;
    assign out_sat   = r_out_sat;

    // Out-of-range channels fall back to x1 / +0; any x8 combination beyond 8 collapses to plain x8.
    always_comb begin
        w_factor_raw = 4'b0100;
        w_addend     = '0;
        if (32'(in_ch) < CHANNELS) begin
            w_factor_raw = r_factor[in_ch];
            w_addend     = r_addend[in_ch];
        end
        w_code = (w_factor_raw[1:0] == 2'b11) ? 4'b0011 : w_factor_raw;
    end

    assign w_zx   = {{4{z[WIDTH-1]}}, z};
    assign w_base = {{4{u[WIDTH-1]}}, u} + {{(IW-ADDEND_WIDTH){w_addend[ADDEND_WIDTH-1]}}, w_addend};

    always_comb begin
        case (w_code[1:0])
            2'b00:   w_t0 = '0;
            2'b01:   w_t0 = w_zx >>> 1;
            2'b10:   w_t0 = w_zx <<< 1;
            default: w_t0 = w_zx <<< 3;
        endcase
        case (w_code[3:2])
            2'b00:   w_t1 = '0;
            2'b01:   w_t1 = w_zx;
            2'b10:   w_t1 = w_zx >>> 2;
            default: w_t1 = w_zx <<< 2;
        endcase
    end

    assign w_sum = r_base + r_t0 + r_t1;

    always_comb begin
        w_sat_val = w_sum[WIDTH-1:0];
        w_clamp   = 1'b0;
        if (w_sum > SAT_MAX) begin
            w_sat_val = SAT_MAX[WIDTH-1:0];
            w_clamp   = 1'b1;
        end else if (w_sum < SAT_MIN) begin
            w_sat_val = SAT_MIN[WIDTH-1:0];
            w_clamp   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < CHANNELS; i++) begin
                r_factor[i] <= 4'b0100;
                r_addend[i] <= '0;
            end
            r_v1        <= 1'b0;
            r_ch1       <= '0;
            r_base      <= '0;
            r_t0        <= '0;
            r_t1        <= '0;
            r_out_valid <= 1'b0;
            r_out_ch    <= '0;
            r_u_out     <= '0;
            r_out_sat   <= 1'b0;
        end else begin
            // Table writes land at the edge, so the sample accepted on the same edge still sees old values.
            if (cfg_we && (32'(cfg_ch) < CHANNELS)) begin
                r_factor[cfg_ch] <= cfg_factor;
                r_addend[cfg_ch] <= cfg_addend;
            end
            if (w_adv) begin
                r_v1 <= in_valid;
                if (in_valid) begin
                    r_ch1  <= in_ch;
                    r_base <= w_base;
                    r_t0   <= w_t0;
                    r_t1   <= w_t1;
                end
                r_out_valid <= r_v1;
                if (r_v1) begin
                    r_out_ch  <= r_ch1;
                    r_u_out   <= w_sat_val;
                    r_out_sat <= w_clamp;
                end
            end
        end
    end
endmodule

// File: tb/tb_batch_norm_pipe.sv
// tb/tb_batch_norm_pipe.sv - randomized and directed scoreboard bench for batch_norm_pipe
// Expected results come from an integer-arithmetic model of the config table and update rule.
module tb_batch_norm_pipe;
    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              cfg_we = 1'b0;
    logic [1:0]        cfg_ch = '0;
    logic [3:0]        cfg_factor = '0;
    logic signed [3:0] cfg_addend = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [1:0]        in_ch = '0;
    logic signed [5:0] u = '0;
    logic signed [5:0] z = '0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [1:0]        out_ch;
    logic signed [5:0] u_out;
    logic              out_sat;

    batch_norm_pipe #(.WIDTH(6), .ADDEND_WIDTH(4), .CHANNELS(4)) dut (
        .clk(clk), .reset(reset),
        .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_factor(cfg_factor), .cfg_addend(cfg_addend),
        .in_valid(in_valid), .in_ready(in_ready), .in_ch(in_ch), .u(u), .z(z),
        .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch), .u_out(u_out), .out_sat(out_sat)
    );

    always #5 clk = ~clk;

    typedef struct {
        int ch;
        int val;
        int sat;
    } exp_t;

    exp_t q[$];
    int   m_factor[4];
    int   m_addend[4];
    int   n_checks = 0;
    int   n_err = 0;
    int   last_u = 0;
    int   last_sat = 0;
    int   n_pops = 0;
    logic obs_in_ready;
    logic have_prev = 1'b0;
    int   prev_u, prev_ch, prev_sat;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int fdiv(input int a, input int b);
        int qv;
        qv = a / b;
        if ((a % b != 0) && (a < 0)) qv--;
        return qv;
    endfunction

    function automatic exp_t model(input int ch, input int uv, input int zv);
        exp_t e;
        int code, lo, hi, s;
        code = m_factor[ch];
        if ((code % 4) == 3) code = 3;
        lo = code % 4;
        hi = code / 4;
        s = uv + m_addend[ch];
        case (lo)
            1: s += fdiv(zv, 2);
            2: s += 2 * zv;
            3: s += 8 * zv;
            default: ;
        endcase
        case (hi)
            1: s += zv;
            2: s += fdiv(zv, 4);
            3: s += 4 * zv;
            default: ;
        endcase
        e.ch = ch;
        e.sat = 0;
        if (s > 31) begin s = 31; e.sat = 1; end
        if (s < -32) begin s = -32; e.sat = 1; end
        e.val = s;
        return e;
    endfunction

    task automatic model_reset();
        q.delete();
        for (int i = 0; i < 4; i++) begin
            m_factor[i] = 4;
            m_addend[i] = 0;
        end
        have_prev = 1'b0;
    endtask

    task automatic step(input logic iv, input int ich, input int iu, input int iz, input logic ord,
                        input logic we, input int wch, input int wf, input int wa, output logic acc);
        exp_t e;
        @(negedge clk);
        in_valid = iv;  in_ch = ich[1:0];  u = iu[5:0];  z = iz[5:0];  out_ready = ord;
        cfg_we = we;  cfg_ch = wch[1:0];  cfg_factor = wf[3:0];  cfg_addend = wa[3:0];
        #1;
        obs_in_ready = in_ready;
        if (have_prev) begin
            check("hold_valid", out_valid, 1);
            check("hold_u", u_out, prev_u);
            check("hold_ch", out_ch, prev_ch);
            check("hold_sat", out_sat, prev_sat);
        end
        have_prev = out_valid && !out_ready;
        prev_u = u_out;  prev_ch = out_ch;  prev_sat = out_sat;
        if (out_valid && out_ready) begin
            if (q.size() == 0) begin
                check("extra_output", 1, 0);
            end else begin
                e = q.pop_front();
                check("out_ch", out_ch, e.ch);
                check("u_out", u_out, e.val);
                check("out_sat", out_sat, e.sat);
                last_u = u_out;
                last_sat = out_sat;
                n_pops++;
            end
        end
        acc = iv && in_ready;
        if (acc) q.push_back(model(ich, iu, iz));
        if (we) begin
            m_factor[wch] = wf;
            m_addend[wch] = wa;
        end
    endtask

    task automatic idle(input logic ord);
        logic a;
        step(1'b0, 0, 0, 0, ord, 1'b0, 0, 0, 0, a);
    endtask

    task automatic send(input int ch, input int uv, input int zv);
        logic a;
        step(1'b1, ch, uv, zv, 1'b1, 1'b0, 0, 0, 0, a);
        check("send_accept", a, 1);
    endtask

    task automatic cfg(input int ch, input int f, input int a);
        logic acc;
        step(1'b0, 0, 0, 0, 1'b1, 1'b1, ch, f, a, acc);
    endtask

    task automatic flush();
        for (int i = 0; i < 20 && q.size() > 0; i++) idle(1'b1);
        check("flush_done", q.size(), 0);
    endtask

    // Reset is asserted together with a config write and a valid sample to show it wins.
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;  in_valid = 1'b1;  in_ch = 2'd0;  u = 6'sd7;  z = 6'sd7;
        cfg_we = 1'b1;  cfg_ch = 2'd0;  cfg_factor = 4'b0011;  cfg_addend = 4'sd5;  out_ready = 1'b1;
        @(negedge clk);
        reset = 1'b0;  in_valid = 1'b0;  cfg_we = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_u_out", u_out, 0);
        check("rst_out_sat", out_sat, 0);
        check("rst_out_ch", out_ch, 0);
        check("rst_in_ready", in_ready, 1);
        model_reset();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic a;
        int idx, tries;
        int bu[4];
        int bz[4];
        model_reset();
        repeat (2) @(negedge clk);
        do_reset();

        step(1'b1, 0, 5, 3, 1'b1, 1'b0, 0, 0, 0, a);
        idle(1'b1);
        check("lat_cycle1_valid", out_valid, 0);
        idle(1'b1);
        check("lat_cycle2_valid", out_valid, 1);
        flush();
        check("basic_u", last_u, 8);
        check("basic_sat", last_sat, 0);

        cfg(2, 4'b0011, 0);
        send(2, 10, 5);
        flush();
        check("sat_hi_u", last_u, 31);
        check("sat_hi_flag", last_sat, 1);
        send(2, -20, -4);
        flush();
        check("sat_lo_u", last_u, -32);
        check("sat_lo_flag", last_sat, 1);

        cfg(1, 4'b1000, -1);
        send(1, -3, -5);
        flush();
        check("neg_shift_u", last_u, -6);

        cfg(3, 4'b1111, 0);
        send(3, 0, 3);
        flush();
        check("bad_code_u", last_u, 24);

        bu = '{3, -7, 12, 0};
        bz = '{1, 2, -3, 4};
        idx = 0;
        n_pops = 0;
        for (int c = 0; c < 14; c++) begin
            if (idx < 4)
                step(1'b1, idx, bu[idx], bz[idx], (c == 0) || (c >= 9), 1'b0, 0, 0, 0, a);
            else
                idle((c == 0) || (c >= 9));
            if (a && idx < 4) idx++;
            if (c == 4) check("bp_in_ready_low", obs_in_ready, 0);
            if (c == 6) check("bp_out_valid_held", out_valid, 1);
        end
        flush();
        check("bp_all_sent", idx, 4);
        check("bp_pop_count", n_pops, 4);

        step(1'b1, 0, 1, 0, 1'b1, 1'b1, 0, 4'b0100, 2, a);
        flush();
        check("collide_old_cfg", last_u, 1);
        send(0, 1, 0);
        flush();
        check("collide_new_cfg", last_u, 3);

        send(0, 1, 0);
        step(1'b1, 0, 2, 0, 1'b0, 1'b0, 0, 0, 0, a);
        do_reset();
        for (int i = 0; i < 5; i++) begin
            idle(1'b1);
            check("post_rst_no_valid", out_valid, 0);
        end
        send(0, 3, 5);
        flush();
        check("readback_default", last_u, 8);

        for (int c = 0; c < 400; c++) begin
            step(($urandom % 4) != 0, $urandom_range(0, 3), $urandom_range(0, 63) - 32,
                 $urandom_range(0, 63) - 32, ($urandom % 4) != 0,
                 ($urandom % 8) == 0, $urandom_range(0, 3), $urandom_range(0, 15),
                 $urandom_range(0, 15) - 8, a);
        end
        flush();
        tries = 0;
        repeat (3) begin
            idle(1'b1);
            if (out_valid) tries++;
        end
        check("final_no_stray", tries, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
